// File: rtl/aes_pkg.sv
// aes_pkg: AES tables, GF(2^8) helpers and key-schedule steps shared by the
// encrypt and decrypt cores.
package aes_pkg;
    localparam int NB = 4;
    localparam int NK = 4;
    localparam int NR = 10;
    localparam int BLOCK_W = 128;

    typedef enum logic [1:0] {IDLE, KEYEXP, ROUND} aes_state_e;

    localparam logic [2047:0] SBOX_T = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [2047:0] INV_SBOX_T = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

    localparam logic [10:0][7:0] RCON = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10,
                                         8'h08, 8'h04, 8'h02, 8'h01, 8'h00};

    // Tables are stored entry 0 first, so entry b sits 255-b bytes up.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_T[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_T[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        return (i > 4'd10) ? 8'h00 : RCON[i];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] b);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h00;
        p = a;
        for (int i = 0; i < 4; i++) begin
            r = b[i] ? r ^ p : r;
            p = xtime(p);
        end
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] key_fwd_step(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = rk[127:96] ^ sub_word({rk[23:0], rk[31:24]}) ^ {rc, 24'h0};
        w1 = rk[95:64] ^ w0;
        w2 = rk[63:32] ^ w1;
        w3 = rk[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo key_fwd_step: recover the last word first, it feeds SubWord.
    function automatic logic [127:0] key_inv_step(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = rk[31:0] ^ rk[63:32];
        w2 = rk[63:32] ^ rk[95:64];
        w1 = rk[95:64] ^ rk[127:96];
        w0 = rk[127:96] ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
                gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
                gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
                gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)};
    endfunction
endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational inverse round; last_round_i drops InvMixColumns.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_i,
    input  logic [BLOCK_W-1:0] rk_i,
    input  logic               last_round_i,
    output logic [BLOCK_W-1:0] state_o
);
    logic [BLOCK_W-1:0] sub;
    logic [BLOCK_W-1:0] ark;
    logic [BLOCK_W-1:0] mix;

    // Byte (r,c) is at index r+4c; row r rotates right by r columns.
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sub[8*(15-(r+4*c)) +: 8] = inv_sbox(state_i[8*(15-(r+4*((c+4-r)%4))) +: 8]);
        end
        assign mix[96-32*c +: 32] = inv_mix_col(ark[96-32*c +: 32]);
    end

    assign ark = sub ^ rk_i;
    assign state_o = last_round_i ? ark : mix;
endmodule

// File: rtl/aes_inv_core.sv
// aes_inv_core: iterative AES-128 decryptor, key expansion then one inverse round per cycle.
// Define AES_DEC_KEY_CACHE_EN to cache round key 10 and skip expansion on a repeated key.
module aes_inv_core
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BLOCK_W-1:0] ctext,
    input  logic [BLOCK_W-1:0] key,
    output logic               busy,
    output logic               done,
    output logic [BLOCK_W-1:0] ptext
);
    if (NUM_ROUNDS != NR || NR != NK + 6) begin : g_bad_rounds
        $error("aes_inv_core: only NUM_ROUNDS=10 is supported");
    end

    aes_state_e fsm_q, fsm_d;
    logic [3:0] cnt_q, cnt_d;
    logic [BLOCK_W-1:0] data_q, data_d, rk_q, rk_d, ptext_q, ptext_d;
    logic done_q, done_d;
    logic [BLOCK_W-1:0] fwd, prk, rnd;

    assign fwd = key_fwd_step(rk_q, rcon(cnt_q));
    assign prk = key_inv_step(rk_q, rcon(cnt_q + 4'd1));

    aes_inv_round u_round (
        .state_i      (data_q),
        .rk_i         (prk),
        .last_round_i (cnt_q == 4'd0),
        .state_o      (rnd)
    );

`ifdef AES_DEC_KEY_CACHE_EN
    logic [BLOCK_W-1:0] ckey_q, ckey_d, crk_q, crk_d;
    logic cvalid_q, cvalid_d;
    logic hit;
    assign hit = cvalid_q && key == ckey_q;
`endif

    always_comb begin
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        data_d = data_q;
        rk_d = rk_q;
        ptext_d = ptext_q;
        done_d = 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
        ckey_d = ckey_q;
        crk_d = crk_q;
        cvalid_d = cvalid_q;
`endif
        unique case (fsm_q)
            IDLE: if (start) begin
                data_d = ctext;
                rk_d = key;
                cnt_d = 4'd1;
                fsm_d = KEYEXP;
`ifdef AES_DEC_KEY_CACHE_EN
                if (hit) begin
                    data_d = ctext ^ crk_q;
                    rk_d = crk_q;
                    cnt_d = 4'd9;
                    fsm_d = ROUND;
                end else begin
                    ckey_d = key;
                    cvalid_d = 1'b0;
                end
`endif
            end
            KEYEXP: begin
                rk_d = fwd;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd10) begin
                    data_d = data_q ^ fwd;
                    cnt_d = 4'd9;
                    fsm_d = ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
                    crk_d = fwd;
                    cvalid_d = 1'b1;
`endif
                end
            end
            ROUND: begin
                rk_d = prk;
                data_d = rnd;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    ptext_d = rnd;
                    done_d = 1'b1;
                    cnt_d = 4'd0;
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= IDLE;
            cnt_q <= 4'd0;
            data_q <= '0;
            rk_q <= '0;
            ptext_q <= '0;
            done_q <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
            ckey_q <= '0;
            crk_q <= '0;
            cvalid_q <= 1'b0;
`endif
        end else begin
            fsm_q <= fsm_d;
            cnt_q <= cnt_d;
            data_q <= data_d;
            rk_q <= rk_d;
            ptext_q <= ptext_d;
            done_q <= done_d;
`ifdef AES_DEC_KEY_CACHE_EN
            ckey_q <= ckey_d;
            crk_q <= crk_d;
            cvalid_q <= cvalid_d;
`endif
        end
    end

    assign busy = fsm_q != IDLE;
    assign done = done_q;
    assign ptext = ptext_q;
endmodule

// File: tb/tb_aes_inv_core.sv
// tb_aes_inv_core: directed vectors, round-trip through a local encrypt model,
// ignored starts, mid-run reset and key-cache latency.
module tb_aes_inv_core;
    import aes_pkg::*;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
`ifdef AES_DEC_KEY_CACHE_EN
    localparam int HIT_LAT = 10;
`else
    localparam int HIT_LAT = 20;
`endif

    typedef struct {
        logic [127:0] k;
        logic [127:0] ct;
        logic [127:0] pt;
        int           lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst, start, busy, done;
    logic [127:0] ctext, key, ptext;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    aes_inv_core #(.NUM_ROUNDS(10)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .ctext (ctext),
        .key   (key),
        .busy  (busy),
        .done  (done),
        .ptext (ptext)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] pt,
                       input int lat, input string name);
        int n, bc;
        @(negedge clk);
        start = 1'b1;
        key = k;
        ctext = ct;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        bc = 0;
        while (!done && n < 60) begin
            if (busy) bc++;
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, " done"}, done, 1);
        chk({name, " latency"}, n, lat);
        chk({name, " busy cycles"}, bc, lat);
        chk({name, " busy at done"}, busy, 0);
        chk({name, " ptext"}, ptext, pt);
        @(posedge clk);
        #1;
        chk({name, " done single"}, done, 0);
        chk({name, " ptext hold"}, ptext, pt);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Independent forward cipher used to build round-trip ciphertexts.
    function automatic logic [127:0] enc(input logic [127:0] k, input logic [127:0] p);
        logic [127:0] s, t, w;
        logic [31:0] x;
        logic [7:0] rc, a0, a1, a2, a3;
        s = p ^ k;
        w = k;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            x = w[31:0];
            x = {sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0]), sbox(x[31:24])} ^ {rc, 24'h0};
            w[127:96] = w[127:96] ^ x;
            w[95:64] = w[95:64] ^ w[127:96];
            w[63:32] = w[63:32] ^ w[95:64];
            w[31:0] = w[31:0] ^ w[63:32];
            rc = xtime(rc);
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    t[8*(15-(q+4*c)) +: 8] = sbox(s[8*(15-(q+4*((c+q)%4))) +: 8]);
            if (r < 10)
                for (int c = 0; c < 4; c++) begin
                    {a0, a1, a2, a3} = t[96-32*c +: 32];
                    t[96-32*c +: 32] = {gf_mul(a0, 4'd2) ^ gf_mul(a1, 4'd3) ^ a2 ^ a3,
                                        a0 ^ gf_mul(a1, 4'd2) ^ gf_mul(a2, 4'd3) ^ a3,
                                        a0 ^ a1 ^ gf_mul(a2, 4'd2) ^ gf_mul(a3, 4'd3),
                                        gf_mul(a0, 4'd3) ^ a1 ^ a2 ^ gf_mul(a3, 4'd2)};
                end
            s = t ^ w;
        end
        return s;
    endfunction

    initial begin
        vec_t tbl[3];
        logic [127:0] rk[3], rp[3], rc[3];
        logic [127:0] got;
        int ndone, lat, idx, cyc, last;

        rst = 1'b1;
        start = 1'b0;
        key = '0;
        ctext = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset ptext", ptext, 0);
        @(negedge clk);
        rst = 1'b0;

        tbl[0] = '{K1, C1, P1, 20};
        tbl[1] = '{KB, CB, PB, 20};
        tbl[2] = '{128'h0, CZ, 128'h0, 20};
        for (int i = 0; i < 3; i++) run(tbl[i].k, tbl[i].ct, tbl[i].pt, tbl[i].lat, $sformatf("vec%0d", i));

        // App. B with input changes and start pulses at E5/E15 while busy.
        @(negedge clk);
        start = 1'b1;
        key = KB;
        ctext = CB;
        @(posedge clk);
        #1;
        start = 1'b0;
        key = {$urandom, $urandom, $urandom, $urandom};
        ctext = {$urandom, $urandom, $urandom, $urandom};
        ndone = 0;
        lat = 0;
        got = '0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            start = (c == 5 || c == 15);
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                lat = c;
                got = ptext;
            end
        end
        start = 1'b0;
        chk("ignored start done count", ndone, 1);
        chk("ignored start latency", lat, 20);
        chk("ignored start ptext", got, PB);

        // Round trip with start held high back to back.
        for (int i = 0; i < 3; i++) begin
            rk[i] = {$urandom, $urandom, $urandom, $urandom};
            rp[i] = {$urandom, $urandom, $urandom, $urandom};
            rc[i] = enc(rk[i], rp[i]);
        end
        @(negedge clk);
        start = 1'b1;
        key = rk[0];
        ctext = rc[0];
        idx = 0;
        cyc = 0;
        last = 0;
        while (idx < 3 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                chk($sformatf("roundtrip ptext %0d", idx), ptext, rp[idx]);
                chk($sformatf("roundtrip spacing %0d", idx), cyc - last, 21);
                last = cyc;
                idx++;
                if (idx < 3) begin
                    key = rk[idx];
                    ctext = rc[idx];
                end else start = 1'b0;
            end
        end
        start = 1'b0;
        chk("roundtrip count", idx, 3);

        // Reset at E12 discards the block.
        @(negedge clk);
        start = 1'b1;
        key = K1;
        ctext = C1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst ptext", ptext, 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("midrst no done", ndone, 0);
        run(K1, C1, P1, 20, "after midrst");

        // Key reuse: second C.1 hits the cache when it exists.
        do_reset();
        run(K1, C1, P1, 20, "reuse first");
        run(K1, C1, P1, HIT_LAT, "reuse second");
        run(KB, CB, PB, 20, "reuse other key");
        do_reset();
        run(K1, C1, P1, 20, "reuse after rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
